// File: rtl/class_wrr_arbiter_pkg.sv
// Shared definitions for the class weighted round-robin output arbiter.
package class_wrr_arbiter_pkg;

    localparam int DATA_SIZE_DEF = 10;
    localparam int CLASS_BIT     = DATA_SIZE_DEF - 1;
    localparam int WEIGHT1_DEF   = 4;
    localparam int CNT_W_DEF     = 8;

    // Burst counter width covers the full legal WEIGHT1 range 1..15.
    localparam int BURST_W       = 4;

    // State = which FIFO was popped in the previous cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S0   = 2'd1,
        S1   = 2'd2
    } arb_state_t;

endpackage : class_wrr_arbiter_pkg

// File: rtl/class_wrr_arbiter_wrr_sched.sv
// Weighted round-robin scheduler: burst counter plus combinational grant/pop.
module class_wrr_arbiter_wrr_sched
    import class_wrr_arbiter_pkg::*;
#(
    parameter int WEIGHT1 = WEIGHT1_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_fifo0_empty,
    input  logic i_fifo1_empty,
    input  logic i_dest_pause,
    output logic o_pop0,
    output logic o_pop1
);

    localparam logic [BURST_W-1:0] W1 = BURST_W'(WEIGHT1);

    logic [BURST_W-1:0] r_burst_cnt;
    logic               w_grant0;
    logic               w_grant1;

    // Grant decision: class 1 wins until its burst quota is used, class 0 then gets one slot.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!i_reset && !i_dest_pause) begin
            if (!i_fifo1_empty && (i_fifo0_empty || (r_burst_cnt < W1))) begin
                w_grant1 = 1'b1;
            end else if (!i_fifo0_empty) begin
                w_grant0 = 1'b1;
            end
        end
    end

    // Burst counter: counts class 1 grants (saturating), cleared by a class 0 grant, held otherwise.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_burst_cnt <= '0;
        end else if (w_grant1) begin
            if (r_burst_cnt < W1) begin
                r_burst_cnt <= r_burst_cnt + 1'b1;
            end
        end else if (w_grant0) begin
            r_burst_cnt <= '0;
        end
    end

    assign o_pop0 = w_grant0;
    assign o_pop1 = w_grant1;

endmodule : class_wrr_arbiter_wrr_sched

// File: rtl/class_wrr_arbiter.sv
// Output stage of the class switching layer: merges FIFO0/FIFO1 onto one
// registered lane with weighted round-robin, class checking and counters.
module class_wrr_arbiter
    import class_wrr_arbiter_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int WEIGHT1   = WEIGHT1_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo0_empty,
    input  logic                 fifo1_empty,
    input  logic [DATA_SIZE-1:0] data0,
    input  logic [DATA_SIZE-1:0] data1,
    input  logic                 dest_pause,
    output logic                 pop0,
    output logic                 pop1,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 active_class,
    output logic                 class_err,
    output logic [CNT_W-1:0]     cnt0,
    output logic [CNT_W-1:0]     cnt1
);

    // Class bit tracks the MSB when DATA_SIZE is overridden.
    localparam int CB = CLASS_BIT + (DATA_SIZE - DATA_SIZE_DEF);

    logic                 w_pop0;
    logic                 w_pop1;
    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic                 w_capture;
    logic                 w_cap_class;
    logic [DATA_SIZE-1:0] w_cap_data;
    logic [DATA_SIZE-1:0] r_data_out;
    logic                 r_valid_out;
    logic                 r_active_class;
    logic                 r_class_err;
    logic [CNT_W-1:0]     r_cnt0;
    logic [CNT_W-1:0]     r_cnt1;

    class_wrr_arbiter_wrr_sched #(
        .WEIGHT1 (WEIGHT1)
    ) u_sched (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_fifo0_empty (fifo0_empty),
        .i_fifo1_empty (fifo1_empty),
        .i_dest_pause  (dest_pause),
        .o_pop0        (w_pop0),
        .o_pop1        (w_pop1)
    );

    // State register: remembers which FIFO was popped last cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state follows this cycle's grant; a reset grant is already suppressed in the scheduler.
    always_comb begin
        w_state_nxt = IDLE;
        if (w_pop1) begin
            w_state_nxt = S1;
        end else if (w_pop0) begin
            w_state_nxt = S0;
        end
    end

    // State outputs: the popped word is on the FIFO data bus now, select it for capture.
    always_comb begin
        w_capture   = 1'b0;
        w_cap_class = 1'b0;
        w_cap_data  = data0;
        unique case (r_state)
            S1: begin
                w_capture   = 1'b1;
                w_cap_class = 1'b1;
                w_cap_data  = data1;
            end
            S0: begin
                w_capture   = 1'b1;
                w_cap_class = 1'b0;
                w_cap_data  = data0;
            end
            default: begin
                w_capture   = 1'b0;
            end
        endcase
    end

    // Output register: capture the word and its class; data holds when nothing is captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out     <= '0;
            r_valid_out    <= 1'b0;
            r_active_class <= 1'b0;
        end else if (w_capture) begin
            r_data_out     <= w_cap_data;
            r_valid_out    <= 1'b1;
            r_active_class <= w_cap_class;
        end else begin
            r_valid_out    <= 1'b0;
        end
    end

    // Delivered-word counters per class, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_capture) begin
            if (w_cap_class) begin
                r_cnt1 <= r_cnt1 + 1'b1;
            end else begin
                r_cnt0 <= r_cnt0 + 1'b1;
            end
        end
    end

    // Sticky error when a word's class bit disagrees with the FIFO it came from.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_class_err <= 1'b0;
        end else if (w_capture && (w_cap_data[CB] != w_cap_class)) begin
            r_class_err <= 1'b1;
        end
    end

    assign pop0         = w_pop0;
    assign pop1         = w_pop1;
    assign data_out     = r_data_out;
    assign valid_out    = r_valid_out;
    assign active_class = r_active_class;
    assign class_err    = r_class_err;
    assign cnt0         = r_cnt0;
    assign cnt1         = r_cnt1;

endmodule : class_wrr_arbiter
